// File: rtl/data_storer_dp.sv
// Sample store with running 10.10 sum: fills from a valid/ready producer, then on flush drains
// every stored sample in arrival order to a valid/ready consumer and pulses done.
module data_storer_dp #(
    parameter int unsigned DEPTH = 150,
    parameter int unsigned W     = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [7:0]   out_idx,
    output logic [7:0]   count,
    output logic         full,
    output logic [27:0]  sum,
    output logic         done
);

    localparam int unsigned SumW = 28;

    typedef enum logic [1:0] {
        StFill,
        StDrain,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      count_q, count_d;
    logic [7:0]      rd_ptr_q, rd_ptr_d;
    logic [SumW-1:0] sum_q, sum_d;
    // Done pulse for a flush that found nothing to drain; the FSM stays in StFill.
    logic            empty_done_q, empty_done_d;

    logic [W-1:0]    mem [DEPTH];

    logic            full_w;
    logic            wr_en;
    logic            last_rd;

    assign full_w  = (count_q == 8'(DEPTH));
    assign wr_en   = (state_q == StFill) && in_valid && !full_w;
    assign last_rd = (rd_ptr_q == count_q - 8'd1);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        sum_d        = sum_q;
        empty_done_d = 1'b0;
        case (state_q)
            StFill: begin
                if (wr_en) begin
                    count_d = count_q + 8'd1;
                    sum_d   = sum_q + SumW'(in_data);
                end
                // A write landing with the flush is part of this drain.
                if (flush) begin
                    if ((count_q != 8'd0) || wr_en) begin
                        state_d  = StDrain;
                        rd_ptr_d = 8'd0;
                    end else begin
                        empty_done_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                if (out_ready) begin
                    if (last_rd) begin
                        state_d = StDone;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 8'd1;
                    end
                end
            end
            StDone: begin
                state_d  = StFill;
                count_d  = 8'd0;
                sum_d    = '0;
                rd_ptr_d = 8'd0;
            end
            default: begin
                state_d  = StFill;
                count_d  = 8'd0;
                sum_d    = '0;
                rd_ptr_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StFill;
            count_q      <= 8'd0;
            rd_ptr_q     <= 8'd0;
            sum_q        <= '0;
            empty_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            sum_q        <= sum_d;
            empty_done_q <= empty_done_d;
        end
    end

    // Storage is not reset; entries are only read back after being rewritten.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[count_q] <= in_data;
        end
    end

    assign in_ready  = (state_q == StFill) && !full_w;
    assign out_valid = (state_q == StDrain);
    assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
    assign out_idx   = out_valid ? rd_ptr_q : 8'd0;
    assign count     = count_q;
    assign full      = full_w;
    assign sum       = sum_q;
    assign done      = (state_q == StDone) || empty_done_q;

endmodule

// File: tb/tb_data_storer_dp.sv
// Bench for data_storer_dp: directed and randomized fill/drain sequences checked against a
// queue-based model of stored samples and their arithmetic sum.
module tb_data_storer_dp;

    localparam int DEPTH = 150;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] in_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [19:0] out_data;
    logic [7:0]  out_idx;
    logic [7:0]  count;
    logic        full;
    logic [27:0] sum;
    logic        done;

    int n_chk  = 0;
    int n_pass = 0;

    logic [19:0] q[$];

    data_storer_dp #(
        .DEPTH (DEPTH),
        .W     (20)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .count     (count),
        .full      (full),
        .sum       (sum),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic longint model_sum();
        longint s = 0;
        foreach (q[i]) s += longint'(q[i]);
        return s;
    endfunction

    task automatic check_fill_state();
        chk("count", count, q.size());
        chk("sum", sum, 32'(model_sum()));
        chk("full", full, 32'(q.size() == DEPTH));
    endtask

    task automatic write_one(input logic [19:0] d);
        chk("in_ready_fill", in_ready, 32'(q.size() < DEPTH));
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
        if (q.size() < DEPTH) q.push_back(d);
        check_fill_state();
    endtask

    // mode 0: out_ready held high, 1: toggled 1/0, 2: random
    task automatic drain(input int mode, input logic with_hs, input logic [19:0] hs_data);
        int idx = 0;
        int guard = 0;
        int n;
        flush = 1'b1;
        if (with_hs) begin
            in_valid = 1'b1;
            in_data  = hs_data;
        end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        if (with_hs && q.size() < DEPTH) q.push_back(hs_data);
        n = q.size();
        check_fill_state();
        while (idx < n && guard < 4 * n + 20) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (guard % 2 == 0);
                default: out_ready = 1'($urandom % 2);
            endcase
            in_valid = 1'($urandom % 2);
            in_data  = 20'($urandom);
            flush    = 1'($urandom % 2);
            chk("out_valid", out_valid, 1);
            chk("out_idx", out_idx, idx);
            chk("out_data", out_data, q[idx]);
            chk("in_ready_drain", in_ready, 0);
            chk("done_drain", done, 0);
            tick();
            if (out_ready) idx++;
            guard++;
        end
        if (idx < n) chk("drain_timeout", idx, n);
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("done_pulse", done, 1);
        chk("out_valid_done", out_valid, 0);
        chk("out_data_done", out_data, 0);
        chk("out_idx_done", out_idx, 0);
        chk("in_ready_done", in_ready, 0);
        tick();
        q.delete();
        chk("done_after", done, 0);
        chk("count_after", count, 0);
        chk("sum_after", sum, 0);
        chk("in_ready_after", in_ready, 1);
    endtask

    initial begin
        // Reset, including a flush and write offered during reset.
        in_valid = 1'b1;
        in_data  = 20'h00400;
        flush    = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_sum", sum, 0);
        chk("rst_full", full, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_out_data", out_data, 0);

        // Three samples 1.0, 3.0, 4.0 then drain with out_ready held high.
        write_one(20'h00400);
        write_one(20'h00C00);
        write_one(20'h01000);
        chk("sum_8p0", sum, 32'h2000);
        drain(0, 1'b0, '0);

        // Same data drained with out_ready toggling.
        write_one(20'h00400);
        write_one(20'h00C00);
        write_one(20'h01000);
        drain(1, 1'b0, '0);

        // Empty flush: done pulse only, still filling.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("empty_done", done, 1);
        chk("empty_out_valid", out_valid, 0);
        chk("empty_in_ready", in_ready, 1);
        tick();
        chk("empty_done_clr", done, 0);
        chk("empty_out_valid2", out_valid, 0);

        // Flush with a simultaneous write of 1.0 on an empty store.
        drain(0, 1'b1, 20'h00400);

        // Fill to capacity with max samples; an extra write is dropped.
        for (int i = 0; i < DEPTH; i++) write_one(20'hFFFFF);
        chk("full_flag", full, 1);
        chk("full_in_ready", in_ready, 0);
        chk("full_sum", sum, 32'h95FFF6A);
        write_one(20'h12345);
        chk("full_count", count, DEPTH);
        drain(2, 1'b0, '0);

        // Reset at out_idx 1 of a 3-sample drain.
        write_one(20'h00400);
        write_one(20'h00C00);
        write_one(20'h01000);
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        out_ready = 1'b1;
        chk("abort_idx0", out_idx, 0);
        tick();
        chk("abort_idx1", out_idx, 1);
        chk("abort_data1", out_data, 20'h00C00);
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        q.delete();
        chk("abort_out_valid", out_valid, 0);
        chk("abort_count", count, 0);
        chk("abort_sum", sum, 0);
        chk("abort_done", done, 0);
        chk("abort_in_ready", in_ready, 1);
        tick();
        chk("abort_done2", done, 0);

        // Randomized rounds: gapped writes then a randomly throttled drain.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(1, 24));
            for (int i = 0; i < n; i++) begin
                int gap;
                gap = int'($urandom_range(0, 2));
                for (int g = 0; g < gap; g++) tick();
                write_one(20'($urandom));
            end
            drain(2, 1'($urandom % 2), 20'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/data_storer_dp.md
DATA_STORER_DP -- requirements
Module: data_storer_dp

Interface
REQ-001 SHALL have parameter DEPTH, default 150, meaning the maximum number of stored samples.
REQ-002 SHALL have parameter W, default 20, meaning the sample width in 10.10 unsigned fixed point (bits [19:10] integer, [9:0] fraction).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: the producer offers in_data.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept a sample this cycle.
REQ-007 SHALL have port in_data, input, W bits: the sample to store.
REQ-008 SHALL have port flush, input, 1 bit: request to drain all stored samples.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data/out_idx hold a drained sample.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the current output sample.
REQ-011 SHALL have port out_data, output, W bits: the drained sample.
REQ-012 SHALL have port out_idx, output, 8 bits: the storage index of out_data.
REQ-013 SHALL have port count, output, 8 bits: the number of samples stored.
REQ-014 SHALL have port full, output, 1 bit: high when count == DEPTH.
REQ-015 SHALL have port sum, output, 28 bits: the running sum of stored samples, same 10.10 scaling, zero-extended.
REQ-016 SHALL have port done, output, 1 bit: one-cycle pulse marking the end of a drain.

Function
REQ-017 SHALL implement the states FILL, DRAIN and DONE.
REQ-018 In FILL, in_ready SHALL equal !full.
REQ-019 In FILL, a handshake (in_valid && in_ready) SHALL write mem[count] <= in_data, increment count and add in_data to sum, all in the same edge.
REQ-020 When full, in_valid SHALL be ignored; no write, and count and sum stay unchanged.
REQ-021 In FILL, flush with count > 0 SHALL move to DRAIN on the next edge.
REQ-022 A handshake in the same cycle as flush SHALL be stored and included in the drain; its count/sum update lands on the transition edge.
REQ-023 In FILL, flush with count == 0 and no simultaneous handshake SHALL pulse done for one cycle and remain in FILL.
REQ-024 In DRAIN and DONE, in_ready SHALL be 0 and flush SHALL be ignored.
REQ-025 In DRAIN, out_valid SHALL be 1, out_data SHALL equal mem[rd_ptr] and out_idx SHALL equal rd_ptr; rd_ptr starts at 0.
REQ-026 out_data/out_idx SHALL stay stable until out_ready; on out_valid && out_ready, rd_ptr SHALL increment.
REQ-027 The handshake at rd_ptr == count-1 SHALL move to DONE.
REQ-028 DONE SHALL last exactly one cycle with done=1 and out_valid=0, then return to FILL with count=0, sum=0 and rd_ptr=0.
REQ-029 While out_valid=0, out_data and out_idx SHALL read 0.
REQ-030 sum SHALL never wrap: 150*(2^20-1) < 2^28.
REQ-031 Samples SHALL drain in arrival order, with no gaps while out_ready is held high (one sample per cycle).

Reset
REQ-032 rst SHALL force state FILL and set count=0, sum=0, rd_ptr=0, out_valid=0, done=0, full=0 and in_ready=1 (the value seen in the cycle after reset).
REQ-033 rst SHALL take priority over all handshakes and flush in the same cycle.
REQ-034 rst mid-DRAIN SHALL abort the drain and discard stored contents, with no done pulse.
REQ-035 Memory contents need not be cleared by rst; they are unobservable until rewritten.

Verification
REQ-036 Bench SHALL cover: write 3 samples 0x00400, 0x00C00, 0x01000 (1.0, 3.0, 4.0) -> count=3, sum=0x2000 (8.0).
REQ-037 Bench SHALL cover: flush with out_ready=1 -> out_idx 0,1,2 on consecutive cycles with the data above, then done=1 for one cycle, then count=0.
REQ-038 Bench SHALL cover: write 150 samples of 0xFFFFF -> full=1, in_ready=0, sum=0x95FFF6A; a 151st in_valid is not stored.
REQ-039 Bench SHALL cover: out_ready toggled 1/0 during drain -> each sample held until accepted, order preserved, done after the last.
REQ-040 Bench SHALL cover: flush with count=0 -> done pulse next cycle, out_valid stays 0; flush with a simultaneous handshake of 0x00400 -> drain emits that sample.
REQ-041 Bench SHALL cover: rst asserted at out_idx=1 of a 3-sample drain -> next cycle out_valid=0, count=0, sum=0, done=0.
